io_issue_queue: RTL and testbench

- In-order issue queue storage and pointer stage for one backend issue port.
- Sits between dispatch (upstream) and the functional unit (downstream).
- Holds up to QUEUE_SIZE micro-ops in a circular buffer with one-hot enqueue and dequeue pointers.
- Issues strictly oldest-first and removes the youngest entries on a ROB-index-based flush.
- Exports its per-entry valid vector and both pointers so the enqueue-pointer policy stage can consume them.

---
 rtl/io_issue_queue.sv | 180 ++++++++++++++++++
 tb/tb_io_issue_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_issue_queue.sv
// ============================================================================
// Module   : io_issue_queue
// Brief    : In-order issue queue with one-hot circular pointers and a
//            robidx-based youngest-suffix flush. An optional same-cycle
//            bypass for an empty queue is enabled by IO_ISSUE_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_issue_queue #(
    parameter int QUEUE_SIZE    = 8,
    parameter int DATA_WIDTH    = 64,
    parameter int ROB_IDX_WIDTH = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [ROB_IDX_WIDTH:0]        flush_robidx,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [DATA_WIDTH-1:0]         enq_data,
    input  logic [ROB_IDX_WIDTH:0]        enq_robidx,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [DATA_WIDTH-1:0]         deq_data,
    output logic [ROB_IDX_WIDTH:0]        deq_robidx,
    output logic [QUEUE_SIZE-1:0]         valid_dec,
    output logic [QUEUE_SIZE-1:0]         enq_ptr_oh,
    output logic [QUEUE_SIZE-1:0]         deq_ptr_oh,
    output logic [$clog2(QUEUE_SIZE):0]   count
);

    localparam int PTR_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROB_W = ROB_IDX_WIDTH + 1;

    logic [QUEUE_SIZE-1:0] valid_q, valid_d;
    logic [QUEUE_SIZE-1:0] enq_ptr_q, enq_ptr_d;
    logic [QUEUE_SIZE-1:0] deq_ptr_q, deq_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] data_d [QUEUE_SIZE];
    logic [ROB_W-1:0]      rob_q  [QUEUE_SIZE];
    logic [ROB_W-1:0]      rob_d  [QUEUE_SIZE];

    logic                  full;
    logic                  head_valid;
    logic                  bypass;
    logic                  enq_fire;
    logic                  deq_fire;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ROB_W-1:0]      head_rob;
    logic [QUEUE_SIZE-1:0] kill;
    logic [CNT_W-1:0]      survivors;
    logic [QUEUE_SIZE-1:0] flush_enq_ptr;
    logic [PTR_W-1:0]      rot_pos;
    logic                  younger;

    assign full       = (count_q == CNT_W'(QUEUE_SIZE));
    assign enq_ready  = ~full & ~flush;
    assign head_valid = |(valid_q & deq_ptr_q) & ~flush;

`ifdef IO_ISSUE_QUEUE_BYPASS_EN
    assign bypass     = (count_q == '0) & ~flush & enq_valid & deq_ready;
    assign deq_valid  = head_valid | bypass;
    assign deq_data   = bypass ? enq_data   : head_data;
    assign deq_robidx = bypass ? enq_robidx : head_rob;
`else
    assign bypass     = 1'b0;
    assign deq_valid  = head_valid;
    assign deq_data   = head_data;
    assign deq_robidx = head_rob;
`endif

    // A bypassed op is consumed directly, so it must not also be stored.
    assign enq_fire = enq_valid & enq_ready & ~bypass;
    assign deq_fire = head_valid & deq_ready;

    always_comb begin
        head_data = '0;
        head_rob  = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (deq_ptr_q[i]) begin
                head_data = head_data | data_q[i];
                head_rob  = head_rob  | rob_q[i];
            end
        end
    end

    // Flag bit breaks the tie across ROB index wrap.
    always_comb begin
        kill      = '0;
        survivors = '0;
        younger   = 1'b0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (rob_q[i][ROB_IDX_WIDTH] == flush_robidx[ROB_IDX_WIDTH])
                younger = rob_q[i][ROB_IDX_WIDTH-1:0] > flush_robidx[ROB_IDX_WIDTH-1:0];
            else
                younger = rob_q[i][ROB_IDX_WIDTH-1:0] < flush_robidx[ROB_IDX_WIDTH-1:0];
            kill[i] = valid_q[i] & younger;
            if (valid_q[i] & ~younger)
                survivors = survivors + CNT_W'(1);
        end
    end

    // Occupancy is contiguous from the head, so survivors fix the new tail.
    always_comb begin
        flush_enq_ptr = '0;
        rot_pos       = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            rot_pos                = PTR_W'(i) + survivors[PTR_W-1:0];
            flush_enq_ptr[rot_pos] = deq_ptr_q[i];
        end
    end

    always_comb begin
        valid_d   = valid_q;
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        data_d    = data_q;
        rob_d     = rob_q;
        if (flush) begin
            valid_d   = valid_q & ~kill;
            count_d   = survivors;
            enq_ptr_d = flush_enq_ptr;
        end else begin
            if (enq_fire) begin
                for (int i = 0; i < QUEUE_SIZE; i++) begin
                    if (enq_ptr_q[i]) begin
                        data_d[i] = enq_data;
                        rob_d[i]  = enq_robidx;
                    end
                end
                valid_d   = valid_d | enq_ptr_q;
                enq_ptr_d = {enq_ptr_q[QUEUE_SIZE-2:0], enq_ptr_q[QUEUE_SIZE-1]};
            end
            if (deq_fire) begin
                valid_d   = valid_d & ~deq_ptr_q;
                deq_ptr_d = {deq_ptr_q[QUEUE_SIZE-2:0], deq_ptr_q[QUEUE_SIZE-1]};
            end
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= '0;
            enq_ptr_q <= QUEUE_SIZE'(1);
            deq_ptr_q <= QUEUE_SIZE'(1);
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
        rob_q  <= rob_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_enq_onehot: assert ($onehot(enq_ptr_q));
            a_deq_onehot: assert ($onehot(deq_ptr_q));
            a_count_pop:  assert ($countones(valid_q) == int'(count_q));
        end
    end

    assign valid_dec  = valid_q;
    assign enq_ptr_oh = enq_ptr_q;
    assign deq_ptr_oh = deq_ptr_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_io_issue_queue.sv
// ============================================================================
// Module   : tb_io_issue_queue
// Brief    : Directed self-checking bench for io_issue_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_issue_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [6:0]  flush_robidx;
    logic        enq_valid;
    logic        enq_ready;
    logic [63:0] enq_data;
    logic [6:0]  enq_robidx;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_data;
    logic [6:0]  deq_robidx;
    logic [7:0]  valid_dec;
    logic [7:0]  enq_ptr_oh;
    logic [7:0]  deq_ptr_oh;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    io_issue_queue #(
        .QUEUE_SIZE    (8),
        .DATA_WIDTH    (64),
        .ROB_IDX_WIDTH (6)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .flush_robidx (flush_robidx),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_data     (enq_data),
        .enq_robidx   (enq_robidx),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_data     (deq_data),
        .deq_robidx   (deq_robidx),
        .valid_dec    (valid_dec),
        .enq_ptr_oh   (enq_ptr_oh),
        .deq_ptr_oh   (deq_ptr_oh),
        .count        (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [6:0] rob);
        enq_valid  = 1'b1;
        enq_robidx = rob;
        enq_data   = 64'hD000 + 64'(rob);
        tick();
        enq_valid  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   valid_dec,  8'h00);
        check({tag, "_enqptr"},  enq_ptr_oh, 8'h01);
        check({tag, "_deqptr"},  deq_ptr_oh, 8'h01);
        check({tag, "_count"},   count,      4'd0);
        check({tag, "_deqv"},    deq_valid,  1'b0);
        check({tag, "_enqrdy"},  enq_ready,  1'b1);
    endtask

    initial begin
        logic [6:0] nexp;
        reset = 1'b1; flush = 1'b0; flush_robidx = '0;
        enq_valid = 1'b0; enq_data = '0; enq_robidx = '0; deq_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_reset_state("rst");

        // Three ops, no issue
        enq(7'd0); enq(7'd1); enq(7'd2);
        #1;
        check("enq3_count",  count,      4'd3);
        check("enq3_valid",  valid_dec,  8'h07);
        check("enq3_enqptr", enq_ptr_oh, 8'h08);
        check("enq3_deqv",   deq_valid,  1'b1);
        check("enq3_deqrob", deq_robidx, 7'd0);

        // Fill to full
        for (int i = 3; i < 8; i++) enq(7'(i));
        #1;
        check("full_count",  count,      4'd8);
        check("full_enqrdy", enq_ready,  1'b0);
        check("full_valid",  valid_dec,  8'hFF);
        check("full_enqptr", enq_ptr_oh, 8'h01);
        enq_valid = 1'b1; enq_robidx = 7'h55; enq_data = 64'h55;
        tick();
        enq_valid = 1'b0;
        #1;
        check("full_noovf", count, 4'd8);

        // Single dequeue from full
        deq_ready = 1'b1;
        #1;
        check("deq0_rob",  deq_robidx, 7'd0);
        check("deq0_data", deq_data,   64'hD000);
        tick();
        deq_ready = 1'b0;
        #1;
        check("deq0_enqrdy", enq_ready,  1'b1);
        check("deq0_count",  count,      4'd7);
        check("deq0_deqptr", deq_ptr_oh, 8'h02);

        // Steady state: enqueue and dequeue every cycle
        nexp = 7'd1;
        enq_valid = 1'b1; deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            enq_robidx = 7'(8 + k);
            enq_data   = 64'hD000 + 64'(8 + k);
            #1;
            check("ss_rob",  deq_robidx, nexp);
            check("ss_data", deq_data,   64'hD000 + 64'(nexp));
            nexp = nexp + 7'd1;
            tick();
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("ss_count",  count,      4'd7);
        check("ss_deqptr", deq_ptr_oh, 8'h20);
        check("ss_enqptr", enq_ptr_oh, 8'h10);

        // Reset wins over flush and fires
        enq_valid = 1'b1; deq_ready = 1'b1; flush = 1'b1; flush_robidx = '0; reset = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check_reset_state("rstfl");

        // Place robidx 5..10 at positions 2..7
        enq(7'd3); enq(7'd4);
        deq_ready = 1'b1;
        tick(); tick();
        deq_ready = 1'b0;
        for (int r = 5; r <= 10; r++) enq(7'(r));
        #1;
        check("pre_valid",  valid_dec,  8'hFC);
        check("pre_enqptr", enq_ptr_oh, 8'h01);
        check("pre_deqptr", deq_ptr_oh, 8'h04);
        check("pre_count",  count,      4'd6);

        flush = 1'b1; flush_robidx = 7'd7; enq_valid = 1'b1; deq_ready = 1'b1;
        #1;
        check("fl_enqrdy", enq_ready, 1'b0);
        check("fl_deqv",   deq_valid, 1'b0);
        tick();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("fl_valid",  valid_dec,  8'h1C);
        check("fl_count",  count,      4'd3);
        check("fl_enqptr", enq_ptr_oh, 8'h20);
        check("fl_deqptr", deq_ptr_oh, 8'h04);
        check("fl_deqrob", deq_robidx, 7'd5);
        enq(7'd8);
        #1;
        check("fl_resume_valid", valid_dec, 8'h3C);
        check("fl_resume_count", count,     4'd4);

        // Wrap case across the flag bit
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enq(7'h3E); enq(7'h3F); enq(7'h40); enq(7'h41);
        flush = 1'b1; flush_robidx = 7'h3F;
        tick();
        flush = 1'b0;
        #1;
        check("wrap_count",  count,      4'd2);
        check("wrap_valid",  valid_dec,  8'h03);
        check("wrap_enqptr", enq_ptr_oh, 8'h04);

        // Back-to-back flushes, each on its own cycle's state
        flush = 1'b1; flush_robidx = 7'h3E;
        tick(); tick();
        flush = 1'b0;
        #1;
        check("b2b_count",  count,      4'd1);
        check("b2b_valid",  valid_dec,  8'h01);
        check("b2b_enqptr", enq_ptr_oh, 8'h02);

        // Flush that kills everything
        flush = 1'b1; flush_robidx = 7'h3D;
        tick();
        flush = 1'b0;
        #1;
        check("flall_count",  count,      4'd0);
        check("flall_enqptr", enq_ptr_oh, 8'h01);
        check("flall_deqv",   deq_valid,  1'b0);

        // Empty queue with both sides ready
        enq_valid = 1'b1; deq_ready = 1'b1; enq_robidx = 7'h22; enq_data = 64'hCAFE;
        #1;
`ifdef IO_ISSUE_QUEUE_BYPASS_EN
        check("byp_deqv", deq_valid,  1'b1);
        check("byp_rob",  deq_robidx, 7'h22);
        check("byp_data", deq_data,   64'hCAFE);
        tick();
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("byp_count", count,     4'd0);
        check("byp_valid", valid_dec, 8'h00);
`else
        check("lat_deqv0", deq_valid, 1'b0);
        tick();
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("lat_deqv1", deq_valid,  1'b1);
        check("lat_rob",   deq_robidx, 7'h22);
        check("lat_count", count,      4'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
